wam_spawner: RTL and testbench

WAM_SPAWNER -- requirements
Module: wam_spawner

---
 rtl/wam_spawner_if.sv | 32 +++
 rtl/wam_spawner.sv | 131 +++++++++++++
 tb/tb_wam_spawner.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wam_spawner_if.sv
// Whack-a-mole spawner bus: game controls in, board state and event pulses out.
//   tick/en/start/seed/hit/age/rto : driven by the game controller (master)
//   holes/hit_ok/expire/whiff      : per-cycle board view and event pulses
//   hit_cnt/miss_cnt               : saturating score counters
interface wam_spawner_if #(
    parameter int unsigned HOLES = 8,
    parameter int unsigned AGE_W = 4
);
    logic             tick;
    logic             en;
    logic             start;
    logic [15:0]      seed;
    logic [HOLES-1:0] hit;
    logic [AGE_W-1:0] age;
    logic [7:0]       rto;
    logic [HOLES-1:0] holes;
    logic [HOLES-1:0] hit_ok;
    logic [HOLES-1:0] expire;
    logic             whiff;
    logic [15:0]      hit_cnt;
    logic [15:0]      miss_cnt;

    modport master (
        output tick, en, start, seed, hit, age, rto,
        input  holes, hit_ok, expire, whiff, hit_cnt, miss_cnt
    );

    modport slave (
        input  tick, en, start, seed, hit, age, rto,
        output holes, hit_ok, expire, whiff, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/wam_spawner.sv
// Whack-a-mole spawner: LFSR-driven mole placement, per-hole lifetimes,
// hit/expiry detection and saturating score counters.
//   clk   : rising-edge clock
//   clr_n : asynchronous active-low reset
//   bus   : wam_spawner_if slave (controls in, registered board/pulses out)
module wam_spawner #(
    parameter int unsigned HOLES  = 8,
    parameter int unsigned AGE_W  = 4,
    parameter int unsigned MAX_UP = 3
) (
    input  logic         clk,
    input  logic         clr_n,
    wam_spawner_if.slave bus
);
    localparam int unsigned CNT_W    = $clog2(HOLES + 1);
    localparam int unsigned IDX_W    = $clog2(HOLES);
    localparam logic [15:0] RND_RST  = 16'hACE1;
    localparam logic [15:0] RND_TAPS = 16'hB400;

    function automatic logic [CNT_W-1:0] popcnt(input logic [HOLES-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < HOLES; i++) n = n + CNT_W'(v[i]);
        return n;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [CNT_W-1:0] b);
        logic [16:0] s;
        s = 17'(a) + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [15:0]                 rnd_q, rnd_nxt, seed_ld;
    logic [HOLES-1:0]            holes_q, holes_d;
    logic [HOLES-1:0][AGE_W-1:0] life_q, life_d;
    logic [HOLES-1:0]            hit_ok_q, expire_q;
    logic                        whiff_q;
    logic [15:0]                 hit_cnt_q, miss_cnt_q;

    logic [HOLES-1:0]            hit_v, exp_v, kept, cand, cand_rot, pick_rot, spawn_v;
    logic [2*HOLES-1:0]          cand_dbl, pick_dbl;
    logic [IDX_W-1:0]            spawn_base;
    logic                        do_spawn, whiff_d;

    // Galois LFSR, x^16+x^14+x^13+x^11+1 (right-shifting form)
    assign rnd_nxt    = rnd_q[0] ? ((rnd_q >> 1) ^ RND_TAPS) : (rnd_q >> 1);
    assign seed_ld    = (bus.seed == 16'h0000) ? 16'hFFFF : bus.seed;
    assign spawn_base = IDX_W'(rnd_q[15:8] % 8'(HOLES));

    // Per-cycle board update: hits, ageing/expiry, then at most one spawn
    always_comb begin
        hit_v   = bus.hit & holes_q;
        whiff_d = |(bus.hit & ~holes_q);
        exp_v   = '0;
        life_d  = life_q;

        for (int unsigned i = 0; i < HOLES; i++) begin
            if (bus.tick && holes_q[i] && !bus.hit[i]) begin
                if (life_q[i] == bus.age) exp_v[i] = 1'b1;
                else                      life_d[i] = life_q[i] + AGE_W'(1);
            end
        end

        kept = holes_q & ~hit_v & ~exp_v;

        // Candidates were empty at cycle start and are not being hammered.
        // Rotate so the start index sits at bit 0, isolate the lowest set
        // bit, then rotate back.
        cand     = ~holes_q & ~bus.hit;
        cand_dbl = {cand, cand} >> spawn_base;
        cand_rot = cand_dbl[HOLES-1:0];
        pick_rot = cand_rot & (~cand_rot + HOLES'(1));
        pick_dbl = {HOLES'(0), pick_rot} << spawn_base;

        do_spawn = bus.tick && (rnd_q[7:0] < bus.rto) && (32'(popcnt(kept)) < MAX_UP);
        spawn_v  = do_spawn ? (pick_dbl[2*HOLES-1:HOLES] | pick_dbl[HOLES-1:0]) : '0;

        holes_d = kept | spawn_v;

        // Fresh spawns and every non-surviving hole restart at life 0
        for (int unsigned i = 0; i < HOLES; i++) begin
            if (!kept[i]) life_d[i] = '0;
        end
    end

    // State and registered outputs; start beats everything, en=0 blanks the board
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rnd_q      <= RND_RST;
            holes_q    <= '0;
            life_q     <= '0;
            hit_ok_q   <= '0;
            expire_q   <= '0;
            whiff_q    <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (bus.start) begin
            rnd_q      <= seed_ld;
            holes_q    <= '0;
            life_q     <= '0;
            hit_ok_q   <= '0;
            expire_q   <= '0;
            whiff_q    <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (!bus.en) begin
            rnd_q      <= rnd_nxt;
            holes_q    <= '0;
            life_q     <= '0;
            hit_ok_q   <= '0;
            expire_q   <= '0;
            whiff_q    <= 1'b0;
        end else begin
            rnd_q      <= rnd_nxt;
            holes_q    <= holes_d;
            life_q     <= life_d;
            hit_ok_q   <= hit_v;
            expire_q   <= exp_v;
            whiff_q    <= whiff_d;
            hit_cnt_q  <= sat_add(hit_cnt_q, popcnt(hit_v));
            miss_cnt_q <= sat_add(miss_cnt_q, popcnt(exp_v));
        end
    end

    assign bus.holes    = holes_q;
    assign bus.hit_ok   = hit_ok_q;
    assign bus.expire   = expire_q;
    assign bus.whiff    = whiff_q;
    assign bus.hit_cnt  = hit_cnt_q;
    assign bus.miss_cnt = miss_cnt_q;
endmodule

// File: tb/tb_wam_spawner.sv
// Scoreboard bench for wam_spawner: a behavioural game model predicts each
// clock's outputs into a queue; a monitor pops and compares after each edge.
module tb_wam_spawner;
    localparam int HOLES  = 8;
    localparam int AGE_W  = 4;
    localparam int MAX_UP = 3;

    typedef struct {
        logic [7:0]  holes;
        logic [7:0]  hit_ok;
        logic [7:0]  expire;
        logic        whiff;
        logic [15:0] hit_cnt;
        logic [15:0] miss_cnt;
    } exp_t;

    logic clk;
    logic clr_n;
    wam_spawner_if #(.HOLES(HOLES), .AGE_W(AGE_W)) bus();

    wam_spawner #(.HOLES(HOLES), .AGE_W(AGE_W), .MAX_UP(MAX_UP)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t q[$];

    // Model state
    bit m_up[HOLES];
    int m_life[HOLES];
    int m_rnd;
    int m_hc, m_mc;

    // Current control settings
    bit          r_en;
    logic [3:0]  r_age;
    logic [7:0]  r_rto;
    logic [15:0] r_seed;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int lfsr(input int r);
        return (r % 2 == 1) ? ((r / 2) ^ 'hB400) : (r / 2);
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < HOLES; i++) n += int'(m_up[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < HOLES; i++) begin m_up[i] = 0; m_life[i] = 0; end
        m_rnd = 'hACE1;
        m_hc  = 0;
        m_mc  = 0;
    endtask

    // One clock of game rules applied to the model; expected outputs queued
    task automatic model_step(input bit tk, input bit st, input logic [7:0] h);
        exp_t e;
        bit   was[HOLES];
        int   cur, base, j, nh, nm;
        bit   done;
        e.hit_ok = '0; e.expire = '0; e.whiff = 1'b0;
        if (st) begin
            model_reset();
            m_rnd = (r_seed == 16'h0) ? 'hFFFF : int'(r_seed);
        end else begin
            cur   = m_rnd;
            m_rnd = lfsr(m_rnd);
            if (!r_en) begin
                for (int i = 0; i < HOLES; i++) begin m_up[i] = 0; m_life[i] = 0; end
            end else begin
                was = m_up;
                nh = 0; nm = 0;
                for (int i = 0; i < HOLES; i++) begin
                    if (h[i]) begin
                        if (was[i]) begin e.hit_ok[i] = 1'b1; m_up[i] = 0; m_life[i] = 0; nh++; end
                        else e.whiff = 1'b1;
                    end
                end
                if (tk) begin
                    for (int i = 0; i < HOLES; i++) begin
                        if (was[i] && !h[i]) begin
                            if (m_life[i] == int'(r_age)) begin
                                e.expire[i] = 1'b1; m_up[i] = 0; m_life[i] = 0; nm++;
                            end else m_life[i] = (m_life[i] + 1) % (1 << AGE_W);
                        end
                    end
                    if ((cur % 256) < int'(r_rto) && m_count() < MAX_UP) begin
                        base = (cur / 256) % HOLES;
                        done = 0;
                        for (int k = 0; k < HOLES; k++) begin
                            j = (base + k) % HOLES;
                            if (!done && !was[j] && !h[j]) begin m_up[j] = 1; m_life[j] = 0; done = 1; end
                        end
                    end
                end
                m_hc = (m_hc + nh > 'hFFFF) ? 'hFFFF : m_hc + nh;
                m_mc = (m_mc + nm > 'hFFFF) ? 'hFFFF : m_mc + nm;
            end
        end
        for (int i = 0; i < HOLES; i++) e.holes[i] = m_up[i];
        e.hit_cnt  = 16'(m_hc);
        e.miss_cnt = 16'(m_mc);
        q.push_back(e);
    endtask

    task automatic drive(input bit tk, input bit st, input logic [7:0] h);
        bus.tick  = tk;
        bus.start = st;
        bus.hit   = h;
        bus.en    = r_en;
        bus.age   = r_age;
        bus.rto   = r_rto;
        bus.seed  = r_seed;
        model_step(tk, st, h);
    endtask

    task automatic cyc(input bit tk, input bit st, input logic [7:0] h);
        @(negedge clk);
        drive(tk, st, h);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare every predicted clock against the DUT
    initial begin
        logic [7:0] prev;
        exp_t e;
        prev = '0;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("holes",    32'(bus.holes),    32'(e.holes));
                chk("hit_ok",   32'(bus.hit_ok),   32'(e.hit_ok));
                chk("expire",   32'(bus.expire),   32'(e.expire));
                chk("whiff",    32'(bus.whiff),    32'(e.whiff));
                chk("hit_cnt",  32'(bus.hit_cnt),  32'(e.hit_cnt));
                chk("miss_cnt", 32'(bus.miss_cnt), 32'(e.miss_cnt));
                chk("max_up",    32'($countones(bus.holes) <= MAX_UP), 32'd1);
                chk("one_spawn", 32'($countones(bus.holes & ~prev) <= 1), 32'd1);
            end
            prev = bus.holes;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not complete, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] h;
        bit st, tk;

        clr_n = 1'b0;
        r_en = 0; r_age = '0; r_rto = '0; r_seed = '0;
        bus.tick = 0; bus.start = 0; bus.hit = '0; bus.en = 0;
        bus.age = '0; bus.rto = '0; bus.seed = '0;
        #1;
        chk("rst_holes",    32'(bus.holes),    32'd0);
        chk("rst_hit_ok",   32'(bus.hit_ok),   32'd0);
        chk("rst_expire",   32'(bus.expire),   32'd0);
        chk("rst_whiff",    32'(bus.whiff),    32'd0);
        chk("rst_hit_cnt",  32'(bus.hit_cnt),  32'd0);
        chk("rst_miss_cnt", 32'(bus.miss_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        clr_n = 1'b1;
        drive(0, 0, '0);

        // Straight out of reset: LFSR from ACE1, a few spawning ticks
        r_en = 1; r_age = 4'd5; r_rto = 8'd200;
        repeat (6) cyc(1, 0, '0);

        // Zero seed substitutes FFFF; low byte FF means no spawn
        r_seed = 16'h0000; r_rto = 8'd255;
        cyc(0, 1, '0);
        settle();
        chk("seed0_holes",    32'(bus.holes),    32'd0);
        chk("seed0_hit_cnt",  32'(bus.hit_cnt),  32'd0);
        chk("seed0_miss_cnt", 32'(bus.miss_cnt), 32'd0);
        repeat (4) cyc(1, 0, '0);

        // Max-up limit with free spawning
        r_seed = 16'hBEEF; r_age = 4'd15;
        cyc(0, 1, '0);
        repeat (10) cyc(1, 0, '0);

        // age=2 single mole expires on the third tick after spawning
        r_seed = 16'h1234; r_age = 4'd2; r_rto = 8'd255;
        cyc(0, 1, '0);
        cyc(1, 0, '0);
        r_rto = 8'd0;
        repeat (3) cyc(1, 0, '0);
        settle();
        chk("age2_expire",   32'(bus.expire),   32'h04);
        chk("age2_miss_cnt", 32'(bus.miss_cnt), 32'd1);
        chk("age2_holes",    32'(bus.holes),    32'd0);

        // Hit and expiry together on the same hole count as a hit
        r_age = 4'd0; r_rto = 8'd255;
        cyc(0, 1, '0);
        cyc(1, 0, '0);
        r_rto = 8'd0;
        cyc(1, 0, 8'h04);
        settle();
        chk("both_hit_ok",   32'(bus.hit_ok),   32'h04);
        chk("both_expire",   32'(bus.expire),   32'd0);
        chk("both_hit_cnt",  32'(bus.hit_cnt),  32'd1);
        chk("both_miss_cnt", 32'(bus.miss_cnt), 32'd0);

        // Hammer on an empty hole
        cyc(0, 0, 8'h01);
        settle();
        chk("whiff_pulse", 32'(bus.whiff), 32'd1);
        chk("whiff_holes", 32'(bus.holes), 32'd0);
        cyc(0, 0, '0);
        settle();
        chk("whiff_gone",  32'(bus.whiff), 32'd0);

        // Randomized play
        r_age = 4'd3; r_rto = 8'd128;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) r_age = 4'($urandom_range(0, 4));
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 2))
                    0:       r_rto = 8'd0;
                    1:       r_rto = 8'd255;
                    default: r_rto = 8'($urandom);
                endcase
            end
            r_en   = ($urandom_range(0, 24) != 0);
            st     = (n < 2900) && ($urandom_range(0, 149) == 0);
            tk     = 1'($urandom_range(0, 1));
            r_seed = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            for (int i = 0; i < HOLES; i++)
                h[i] = (m_up[i] && $urandom_range(0, 3) == 0) || ($urandom_range(0, 19) == 0);
            cyc(tk, st, h);
        end

        // Mid-game asynchronous reset with moles on the board
        r_en = 1; r_age = 4'd15; r_rto = 8'd255;
        for (int n = 0; n < 40 && m_count() < 2; n++) cyc(1, 0, '0);
        cyc(1, 0, '0);
        @(negedge clk);
        chk("pre_reset_up", 32'($countones(bus.holes) >= 2), 32'd1);
        #2;
        clr_n = 1'b0;
        #1;
        chk("arst_holes",    32'(bus.holes),    32'd0);
        chk("arst_hit_ok",   32'(bus.hit_ok),   32'd0);
        chk("arst_expire",   32'(bus.expire),   32'd0);
        chk("arst_whiff",    32'(bus.whiff),    32'd0);
        chk("arst_hit_cnt",  32'(bus.hit_cnt),  32'd0);
        chk("arst_miss_cnt", 32'(bus.miss_cnt), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        drive(1, 0, '0);
        repeat (8) cyc(1, 0, '0);

        repeat (2) @(posedge clk);
        #3;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
